// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two requesters via round-robin into a framed queue.
// Latency: grant edge k queues the frame, pop at edge k+1, tx_start high for the following cycle.
// Backpressure: grants drop while the queue is full; the FSM waits on tx_busy and a GAP idle.
module uart_tx_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_a,
  input  logic [WIDTH-1:0]                 data_a,
  output logic                             gnt_a,
  input  logic                             req_b,
  input  logic [WIDTH-1:0]                 data_b,
  output logic                             gnt_b,
  output logic                             tx_start,
  output logic [WIDTH+1:0]                 tx_frame,
  input  logic                             tx_busy,
  output logic [$clog2(DEPTH):0]           q_count,
  output logic                             full,
  output logic                             empty,
  output logic [DEPTH-1:0][WIDTH+1:0]      hist
);

  localparam int PW = $clog2(DEPTH);
  localparam int QW = PW + 1;
  localparam int FW = WIDTH + 2;
  localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);
  localparam logic [QW-1:0] DEPTH_Q  = QW'(DEPTH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_SEND      = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  logic [2:0]    state;
  logic [GW-1:0] gap_cnt;
  logic          last_b;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [FW-1:0] mem [DEPTH];
  logic          push;
  logic          pop;
  logic [FW-1:0] push_frame;
  logic [QW-1:0] count_nxt;

  // last_b=1 means B was granted last, so A takes the next tie.
  always_comb begin
    gnt_a      = !reset && req_a && !full && (!req_b || last_b);
    gnt_b      = !reset && req_b && !full && (!req_a || !last_b);
    push       = gnt_a || gnt_b;
    push_frame = gnt_a ? {1'b1, data_a, 1'b0} : {1'b1, data_b, 1'b0};
    pop        = (state == S_IDLE) && !empty;
  end

  always_comb begin
    count_nxt = q_count;
    if (push && !pop)
      count_nxt = q_count + QW'(1);
    else if (pop && !push)
      count_nxt = q_count - QW'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= push_frame;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_b  <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
    end else begin
      if (push) begin
        last_b <= gnt_b;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      q_count <= count_nxt;
      full    <= (count_nxt == DEPTH_Q);
      empty   <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      gap_cnt  <= '0;
      tx_start <= 1'b0;
      tx_frame <= '1;
      hist     <= '0;
    end else begin
      tx_start <= pop;
      case (state)
        S_IDLE: begin
          if (pop) begin
            tx_frame <= mem[rd_ptr];
            hist     <= {hist[DEPTH-2:0], mem[rd_ptr]};
            state    <= S_START;
          end
        end
        S_START:     state <= S_WAIT_BUSY;
        S_WAIT_BUSY: if (tx_busy) state <= S_SEND;
        S_SEND: begin
          if (!tx_busy) begin
            if (GAP == 0) begin
              state <= S_IDLE;
            end else begin
              gap_cnt <= GAP_LOAD;
              state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt <= GW'(1))
            state <= S_IDLE;
          else
            gap_cnt <= gap_cnt - GW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (WIDTH=8, DEPTH=4, GAP=2); bench drives tx_busy by hand.
module tb_uart_tx_arbiter;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_a, req_b;
  logic [7:0]       data_a, data_b;
  logic             gnt_a, gnt_b;
  logic             tx_start;
  logic [9:0]       tx_frame;
  logic             tx_busy;
  logic [2:0]       q_count;
  logic             full, empty;
  logic [3:0][9:0]  hist;

  int tests = 0;
  int fails = 0;

  uart_tx_arbiter #(.WIDTH(8), .DEPTH(4), .GAP(2)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .data_a(data_a), .gnt_a(gnt_a),
    .req_b(req_b), .data_b(data_b), .gnt_b(gnt_b),
    .tx_start(tx_start), .tx_frame(tx_frame), .tx_busy(tx_busy),
    .q_count(q_count), .full(full), .empty(empty), .hist(hist)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(output logic [9:0] f);
    int n;
    n = 0;
    while (tx_start !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("tx_start_timeout", 64'(n < 40), 64'd1);
    f = tx_frame;
  endtask

  // Move the FSM from START through WAIT_BUSY into SEND with tx_busy low again.
  task automatic serve();
    tick();
    tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
  endtask

  logic [9:0]      f;
  logic [9:0]      exp_f;
  logic [3:0][9:0] exp_hist;
  logic            seen;

  initial begin
    reset = 1'b1; req_a = 1'b1; req_b = 1'b0;
    data_a = 8'h00; data_b = 8'h00; tx_busy = 1'b0;
    tick(); tick();
    chk("reset_gnt_a", gnt_a, 0);
    chk("reset_tx_start", tx_start, 0);
    chk("reset_tx_frame", tx_frame, 10'h3FF);
    chk("reset_q_count", q_count, 0);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_hist", hist, 0);
    req_a = 1'b0;
    reset = 1'b0;
    tick();

    // Single request
    req_a = 1'b1; data_a = 8'hA5; #1;
    chk("single_gnt_a", gnt_a, 1);
    chk("single_gnt_b", gnt_b, 0);
    tick();
    req_a = 1'b0;
    chk("single_qcount1", q_count, 1);
    chk("single_start_early", tx_start, 0);
    tick();
    chk("single_tx_start", tx_start, 1);
    chk("single_tx_frame", tx_frame, 10'b1_10100101_0);
    chk("single_hist0", hist[0], 10'h34A);
    chk("single_qcount0", q_count, 0);
    chk("single_empty", empty, 1);
    tick();
    chk("single_start_pulse", tx_start, 0);
    tx_busy = 1'b1; tick(); tx_busy = 1'b0;
    repeat (4) tick();

    // Fresh reset so the tie starts with A
    reset = 1'b1; tick(); reset = 1'b0;

    // Tie round-robin, then fill to full with transmitter busy
    req_a = 1'b1; req_b = 1'b1; data_a = 8'h11; data_b = 8'h22; #1;
    chk("tie0_gnt_a", gnt_a, 1);
    chk("tie0_gnt_b", gnt_b, 0);
    tick();
    chk("tie1_gnt_b", gnt_b, 1);
    chk("tie1_gnt_a", gnt_a, 0);
    tick();
    chk("tie_first_frame", tx_frame, 10'h222);
    chk("tie_first_start", tx_start, 1);
    chk("tie2_gnt_a", gnt_a, 1);
    tx_busy = 1'b1;
    tick();
    chk("tie3_gnt_b", gnt_b, 1);
    tick();
    chk("tie4_gnt_a", gnt_a, 1);
    tick();
    chk("full_flag", full, 1);
    chk("full_qcount", q_count, 4);
    chk("full_gnt_a", gnt_a, 0);
    chk("full_gnt_b", gnt_b, 0);
    req_b = 1'b0; #1;
    chk("full_gnt_a_alone", gnt_a, 0);
    tx_busy = 1'b0;
    tick(); tick(); tick();
    chk("full_idle_gnt_a", gnt_a, 0);
    tick();
    chk("pop_full_clear", full, 0);
    chk("pop_gnt_a_back", gnt_a, 1);
    chk("pop_frame_22", tx_frame, 10'h244);
    chk("pop_start", tx_start, 1);
    req_a = 1'b0;

    // Gap: second tx_start exactly 4 cycles after tx_busy falls
    tick();
    tx_busy = 1'b1;
    repeat (10) tick();
    tx_busy = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      tick();
      seen = seen | tx_start;
    end
    chk("gap_no_early_start", seen, 0);
    tick();
    chk("gap_start_at_4", tx_start, 1);
    chk("gap_frame_11", tx_frame, 10'h222);
    serve();
    wait_start(f);
    chk("drain_frame_22", f, 10'h244);
    serve();
    wait_start(f);
    chk("drain_frame_11", f, 10'h222);
    serve();
    repeat (4) tick();
    chk("drain_empty", empty, 1);

    // Wrap-around: nine single enqueue/send pairs
    for (int i = 0; i < 9; i++) begin
      req_a = 1'b1; data_a = 8'h30 + 8'(i); #1;
      tick();
      req_a = 1'b0;
      wait_start(f);
      exp_f = {1'b1, 8'h30 + 8'(i), 1'b0};
      chk($sformatf("wrap_frame_%0d", i), f, exp_f);
      serve();
      repeat (4) tick();
    end
    exp_hist[0] = 10'h270;
    exp_hist[1] = 10'h26E;
    exp_hist[2] = 10'h26C;
    exp_hist[3] = 10'h26A;
    chk("wrap_hist", hist, exp_hist);

    // Reset with three frames queued and the FSM in SEND
    req_a = 1'b1; data_a = 8'h55; #1;
    tick(); data_a = 8'h66;
    tick(); data_a = 8'h77; tx_busy = 1'b1;
    tick(); data_a = 8'h88;
    tick(); req_a = 1'b0;
    chk("midop_qcount3", q_count, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midop_qcount0", q_count, 0);
    chk("midop_empty", empty, 1);
    chk("midop_full", full, 0);
    chk("midop_tx_frame", tx_frame, 10'h3FF);
    chk("midop_hist", hist, 0);
    seen = tx_start;
    repeat (3) begin
      tick();
      seen = seen | tx_start;
    end
    chk("midop_no_start", seen, 0);
    tx_busy = 1'b0;
    req_b = 1'b1; data_b = 8'h9C; #1;
    chk("post_reset_gnt_b", gnt_b, 1);
    chk("post_reset_gnt_a", gnt_a, 0);
    tick();
    req_b = 1'b0;
    chk("post_reset_qcount", q_count, 1);
    wait_start(f);
    chk("post_reset_frame", f, 10'h338);
    chk("post_reset_hist0", hist[0], 10'h338);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
